// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP port controller: memory targets,
// command codes and the write-FIFO entry layout.
package vdp_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    VRAM  = 2'b01,
    CRAM  = 2'b10,
    VSRAM = 2'b11
  } vdp_target_t;

  localparam logic [3:0] CODE_VRAM_WR  = 4'b0001;
  localparam logic [3:0] CODE_CRAM_WR  = 4'b0011;
  localparam logic [3:0] CODE_VSRAM_WR = 4'b0101;

  localparam logic [4:0] AUTO_INC_REG = 5'd15;

  typedef struct packed {
    vdp_target_t target;
    logic [15:0] addr;
    logic [15:0] data;
  } vdp_entry_t;

  // Only the low four code bits select a write target; reads and DMA codes map to NONE.
  function automatic vdp_target_t decode_target(input logic [3:0] code);
    vdp_target_t tgt;
    case (code)
      CODE_VRAM_WR:  tgt = VRAM;
      CODE_CRAM_WR:  tgt = CRAM;
      CODE_VSRAM_WR: tgt = VSRAM;
      default:       tgt = NONE;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/vdp_wr_fifo.sv
// Synchronous FIFO of VDP write entries with registered full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module vdp_wr_fifo
  import vdp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  vdp_entry_t                    push_data,
  input  logic                          pop,
  output vdp_entry_t                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  vdp_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; stale slots are never visible because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP data/control port front end: decodes control words into register writes
// or address/code commands and queues data writes towards VRAM/CRAM/VSRAM.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int NUM_REGS   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_wr,
  input  logic              ctrl_wr,
  input  logic [15:0]       wdata,
  output logic              reg_we,
  output logic [4:0]        reg_idx,
  output logic [7:0]        reg_val,
  output logic              mem_req,
  output logic [1:0]        mem_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              ovf_err
);

  // Handshake: mem_req is high whenever the FIFO holds an entry; the head
  // fields stay stable until a cycle with mem_req && mem_ack pops it.

  logic [5:0]   code;
  logic [15:0]  addr;
  logic         pending;
  logic [7:0]   auto_inc;

  vdp_target_t  data_tgt;
  vdp_entry_t   push_data;
  vdp_entry_t   head;
  logic         push;
  logic         pop;
  logic         is_reg_wr;
  logic         reg_idx_ok;
  logic         overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign data_tgt   = decode_target(code[3:0]);
  assign is_reg_wr  = ctrl_wr && !pending && (wdata[15:14] == 2'b10);
  assign reg_idx_ok = (int'(wdata[12:8]) < NUM_REGS);
  assign push       = data_wr && (data_tgt != NONE);
  assign pop        = mem_ack && !fifo_empty;
  assign overflow   = push && fifo_full && !pop;

  always_comb begin
    push_data        = '0;
    push_data.target = data_tgt;
    push_data.addr   = addr;
    push_data.data   = wdata;
  end

  vdp_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_req    = !fifo_empty;
  assign mem_target = fifo_empty ? 2'b00 : head.target;
  assign mem_addr   = fifo_empty ? '0 : head.addr[ADDR_W-1:0];
  assign mem_data   = fifo_empty ? 16'h0000 : head.data;

  // Control effects are written after data effects so they win on a shared cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      code     <= '0;
      addr     <= '0;
      pending  <= 1'b0;
      auto_inc <= '0;
      ovf_err  <= 1'b0;
      reg_we   <= 1'b0;
      reg_idx  <= '0;
      reg_val  <= '0;
    end else begin
      reg_we <= 1'b0;
      if (data_wr) begin
        pending <= 1'b0;
        addr    <= addr + {8'h00, auto_inc};
        if (overflow) begin
          ovf_err <= 1'b1;
        end
      end
      if (ctrl_wr) begin
        if (is_reg_wr) begin
          if (reg_idx_ok) begin
            reg_we  <= 1'b1;
            reg_idx <= wdata[12:8];
            reg_val <= wdata[7:0];
          end
          if (wdata[12:8] == AUTO_INC_REG) begin
            auto_inc <= wdata[7:0];
          end
        end else if (!pending) begin
          code[1:0]  <= wdata[15:14];
          addr[13:0] <= wdata[13:0];
          pending    <= 1'b1;
        end else begin
          code[5:2]   <= wdata[7:4];
          addr[15:14] <= wdata[1:0];
          pending     <= 1'b0;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{fifo_count, code[5:4]};

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed scenarios plus a randomized phase, all
// checked against a transaction-level model of the port rules.
module tb_vdp_port_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_wr;
  logic        ctrl_wr;
  logic [15:0] wdata;
  logic        reg_we;
  logic [4:0]  reg_idx;
  logic [7:0]  reg_val;
  logic        mem_req;
  logic [1:0]  mem_target;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  // Model: queue entries are {target[1:0], addr[15:0], data[15:0]}.
  logic [33:0] exp_q[$];
  logic [5:0]  m_code;
  logic [15:0] m_addr;
  logic        m_pending;
  logic [7:0]  m_inc;
  logic        m_ovf;
  logic        m_we;

  vdp_port_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data_wr    (data_wr),
    .ctrl_wr    (ctrl_wr),
    .wdata      (wdata),
    .reg_we     (reg_we),
    .reg_idx    (reg_idx),
    .reg_val    (reg_val),
    .mem_req    (mem_req),
    .mem_target (mem_target),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] tgt_of(input logic [5:0] c);
    if (c[3:0] == 4'h1) return 2'b01;
    if (c[3:0] == 4'h3) return 2'b10;
    if (c[3:0] == 4'h5) return 2'b11;
    return 2'b00;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; data_wr = 1'b0; ctrl_wr = 1'b0; wdata = '0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_code = '0; m_addr = '0; m_pending = 1'b0; m_inc = '0; m_ovf = 1'b0; m_we = 1'b0;
  endtask

  // Drives one cycle and advances the model by the same write/ack event.
  task automatic step(input logic d, input logic c, input logic [15:0] w, input logic a);
    int          pre;
    logic        pop;
    logic        do_push;
    logic [1:0]  tgt;
    logic [15:0] n_addr;
    logic [5:0]  n_code;
    logic        n_pend;
    @(negedge clk);
    data_wr = d; ctrl_wr = c; wdata = w; mem_ack = a;
    pre = exp_q.size();
    pop = a && (pre > 0);
    do_push = 1'b0;
    tgt = tgt_of(m_code);
    n_addr = m_addr; n_code = m_code; n_pend = m_pending; m_we = 1'b0;
    if (d) begin
      if (tgt != 2'b00) begin
        if (pre < DEPTH || pop) do_push = 1'b1;
        else m_ovf = 1'b1;
      end
      n_addr = m_addr + {8'h00, m_inc};
      n_pend = 1'b0;
    end
    if (c) begin
      if (!m_pending && w[15:14] == 2'b10) begin
        if (w[12:8] < 5'd24) m_we = 1'b1;
        if (w[12:8] == 5'd15) m_inc = w[7:0];
      end else if (!m_pending) begin
        n_code[1:0] = w[15:14]; n_addr[13:0] = w[13:0]; n_pend = 1'b1;
      end else begin
        n_code[5:2] = w[7:4]; n_addr[15:14] = w[1:0]; n_pend = 1'b0;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({tgt, m_addr, w});
    m_addr = n_addr; m_code = n_code; m_pending = n_pend;
    @(posedge clk);
    #1;
    data_wr = 1'b0; ctrl_wr = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
    checks++; if ({reg_idx, reg_val} !== 13'h0) begin errors++; $display("FAIL reset_reg_out got %h want 0", {reg_idx, reg_val}); end
    checks++; if ({mem_target, mem_addr, mem_data} !== 34'h0) begin errors++; $display("FAIL reset_mem_out got %h want 0", {mem_target, mem_addr, mem_data}); end
  endtask

  task automatic test_reg_write();
    step(0, 1, 16'h8F02, 0);
    checks++; if ({reg_we, reg_idx, reg_val} !== {1'b1, 5'd15, 8'h02}) begin errors++; $display("FAIL regwr_15 got %b/%0d/%h want 1/15/02", reg_we, reg_idx, reg_val); end
    step(0, 0, 16'h0000, 0);
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL regwr_pulse got %b want 0", reg_we); end
    step(0, 1, 16'h8105, 0);
    checks++; if ({reg_we, reg_idx, reg_val} !== {1'b1, 5'd1, 8'h05}) begin errors++; $display("FAIL regwr_pending0 got %b/%0d/%h want 1/1/05", reg_we, reg_idx, reg_val); end
    step(0, 1, 16'h9811, 0);
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL regwr_idx24 got %b want 0", reg_we); end
  endtask

  task automatic test_cmd_overflow();
    logic [15:0] data_tab [4];
    data_tab[0] = 16'h2222; data_tab[1] = 16'h3333; data_tab[2] = 16'h4444; data_tab[3] = 16'h5555;
    step(0, 1, 16'h4000, 0);
    step(0, 1, 16'h0000, 0);
    step(1, 0, 16'h1111, 0);
    step(1, 0, 16'h2222, 0);
    step(1, 0, 16'h3333, 0);
    checks++; if ({mem_req, mem_target, mem_addr, mem_data} !== {1'b1, 2'b01, 16'h0000, 16'h1111}) begin errors++; $display("FAIL cmd_head got %b/%b/%h/%h want 1/01/0000/1111", mem_req, mem_target, mem_addr, mem_data); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL cmd_full3 got %b want 0", fifo_full); end
    step(1, 0, 16'h4444, 0);
    checks++; if ({fifo_full, ovf_err} !== 2'b10) begin errors++; $display("FAIL fill4 full/ovf got %b want 10", {fifo_full, ovf_err}); end
    step(1, 0, 16'h5555, 1);
    checks++; if ({fifo_full, ovf_err, mem_addr, mem_data} !== {2'b10, 16'h0002, 16'h2222}) begin errors++; $display("FAIL push_pop_full got %b/%h/%h want 10/0002/2222", {fifo_full, ovf_err}, mem_addr, mem_data); end
    step(1, 0, 16'h6666, 0);
    checks++; if ({fifo_full, ovf_err} !== 2'b11) begin errors++; $display("FAIL overflow full/ovf got %b want 11", {fifo_full, ovf_err}); end
    step(0, 0, 16'h0000, 0);
    checks++; if ({mem_addr, mem_data} !== {16'h0002, 16'h2222}) begin errors++; $display("FAIL head_stable got %h/%h want 0002/2222", mem_addr, mem_data); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, mem_addr, mem_data} !== {1'b1, 16'(2 + 2 * i), data_tab[i]}) begin
        errors++; $display("FAIL drain_%0d got %b/%h/%h want 1/%h/%h", i, mem_req, mem_addr, mem_data, 16'(2 + 2 * i), data_tab[i]);
      end
      step(0, 0, 16'h0000, 1);
    end
    checks++; if ({fifo_empty, mem_req, fifo_full} !== 3'b100) begin errors++; $display("FAIL drained got %b want 100", {fifo_empty, mem_req, fifo_full}); end
    step(0, 0, 16'h0000, 1);
    checks++; if ({fifo_empty, ovf_err} !== 2'b11) begin errors++; $display("FAIL ack_empty got %b want 11", {fifo_empty, ovf_err}); end
    step(1, 0, 16'h7777, 0);
    checks++; if ({mem_req, mem_addr, mem_data} !== {1'b1, 16'h000C, 16'h7777}) begin errors++; $display("FAIL addr_adv got %b/%h/%h want 1/000c/7777", mem_req, mem_addr, mem_data); end
    step(0, 0, 16'h0000, 1);
  endtask

  task automatic test_cram_wrap();
    step(0, 1, 16'hFFFF, 0);
    step(0, 1, 16'h0023, 0);
    step(1, 0, 16'hDEAD, 0);
    checks++; if ({fifo_empty, mem_req} !== 2'b10) begin errors++; $display("FAIL none_target got %b want 10", {fifo_empty, mem_req}); end
    step(0, 1, 16'hFFFF, 0);
    step(0, 1, 16'h0003, 0);
    step(1, 0, 16'hAAAA, 0);
    step(1, 0, 16'hBBBB, 0);
    checks++; if ({mem_target, mem_addr, mem_data} !== {2'b10, 16'hFFFF, 16'hAAAA}) begin errors++; $display("FAIL cram_head got %b/%h/%h want 10/ffff/aaaa", mem_target, mem_addr, mem_data); end
    step(0, 0, 16'h0000, 1);
    checks++; if ({mem_target, mem_addr, mem_data} !== {2'b10, 16'h0001, 16'hBBBB}) begin errors++; $display("FAIL cram_wrap got %b/%h/%h want 10/0001/bbbb", mem_target, mem_addr, mem_data); end
    step(0, 0, 16'h0000, 1);
  endtask

  task automatic test_pending_reset();
    step(0, 1, 16'h4000, 0);
    step(1, 0, 16'h1234, 0);
    step(0, 1, 16'h8123, 0);
    checks++; if ({reg_we, reg_idx, reg_val} !== {1'b1, 5'd1, 8'h23}) begin errors++; $display("FAIL pend_clear got %b/%0d/%h want 1/1/23", reg_we, reg_idx, reg_val); end
    checks++; if ({mem_target, mem_addr, mem_data} !== {2'b01, 16'h0000, 16'h1234}) begin errors++; $display("FAIL pend_entry got %b/%h/%h want 01/0000/1234", mem_target, mem_addr, mem_data); end
    step(0, 0, 16'h0000, 1);
  endtask

  task automatic test_random();
    int          op;
    logic [15:0] w;
    logic [4:0]  idx;
    logic [7:0]  val;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      w = 16'($urandom);
      if (op >= 8) begin
        if (m_pending) begin
          w = {8'h00, 3'b000, 1'($urandom_range(0, 1)), 4'($urandom)};
        end else if ($urandom_range(0, 2) == 0) begin
          idx = 5'($urandom);
          val = (idx == 5'd15) ? 8'($urandom_range(0, 4)) : 8'($urandom);
          w = {3'b100, idx, val};
        end
      end
      step(op >= 4 && op < 8, op >= 8, w, $urandom_range(0, 3) == 0);
      checks++; if (reg_we !== m_we) begin errors++; $display("FAIL rnd_reg_we cyc %0d got %b want %b", n, reg_we, m_we); end
      if (m_we) begin
        checks++; if ({reg_idx, reg_val} !== w[12:0]) begin errors++; $display("FAIL rnd_reg cyc %0d got %h want %h", n, {reg_idx, reg_val}, w[12:0]); end
      end
      checks++;
      if ({mem_req, fifo_empty, fifo_full, ovf_err} !== {exp_q.size() > 0, exp_q.size() == 0, exp_q.size() == DEPTH, m_ovf}) begin
        errors++; $display("FAIL rnd_status cyc %0d got %b want %b", n, {mem_req, fifo_empty, fifo_full, ovf_err},
                           {exp_q.size() > 0, exp_q.size() == 0, exp_q.size() == DEPTH, m_ovf});
      end
      if (exp_q.size() > 0) begin
        checks++; if ({mem_target, mem_addr, mem_data} !== exp_q[0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h want %h", n, {mem_target, mem_addr, mem_data}, exp_q[0]); end
      end
    end
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) step(0, 0, 16'h0000, 1);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rnd_drain got %b want 1", fifo_empty); end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    step(0, 1, 16'h4000, 0);
    step(0, 1, 16'h0000, 0);
    step(0, 1, 16'h8F01, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'hA000 + i), 0);
    checks++; if ({fifo_full, ovf_err} !== 2'b11) begin errors++; $display("FAIL mid_prefill got %b want 11", {fifo_full, ovf_err}); end
    step(0, 1, 16'h4000, 0);
    apply_reset();
    checks++; if ({fifo_empty, mem_req, fifo_full, ovf_err} !== 4'b1000) begin errors++; $display("FAIL mid_reset got %b want 1000", {fifo_empty, mem_req, fifo_full, ovf_err}); end
    step(0, 1, 16'h8A05, 0);
    checks++; if ({reg_we, reg_idx, reg_val} !== {1'b1, 5'd10, 8'h05}) begin errors++; $display("FAIL mid_pending got %b/%0d/%h want 1/10/05", reg_we, reg_idx, reg_val); end
    step(1, 0, 16'h5A5A, 0);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_code_cleared got %b want 1", fifo_empty); end
  endtask

  initial begin
    rst = 1'b1; data_wr = 1'b0; ctrl_wr = 1'b0; wdata = '0; mem_ack = 1'b0;
    test_reset();
    test_reg_write();
    test_cmd_overflow();
    test_cram_wrap();
    test_pending_reset();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
